// File: rtl/quarter_lane.sv
// One ChaCha column lane with its own round sequencer. Diagonal rounds are
// formed by passing b/c/d around a ring of four lanes via the neighbour ports.
module quarter_lane #(
  parameter logic [31:0] A_INIT        = 32'h0,
  parameter logic [1:0]  ADDR_HI       = 2'd0,
  parameter int          DOUBLE_ROUNDS = 10,
  parameter int          FEED_FWD      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write,
  input  logic        start,
  input  logic [5:0]  addr_in,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic [31:0] b_nbr_in,
  input  logic [31:0] c_nbr_in,
  input  logic [31:0] d_nbr_in,
  output logic [31:0] b_out,
  output logic [31:0] c_out,
  output logic [31:0] d_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE, COL0, COL1, COL2, COL3, SH0, SH1, SH2,
    DIAG0, DIAG1, DIAG2, DIAG3, UN0, UN1, UN2, FF
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(DOUBLE_ROUNDS - 1);

  state_e      state_q, state_d, state_nxt;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [31:0] a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
  logic [31:0] sa_q, sb_q, sc_q, sd_q, sa_d, sb_d, sc_d, sd_d;
  logic [31:0] sum_ab, sum_cd, mix_d, mix_b, rd_word;
  logic [1:0]  row, col, bsel;
  logic        col_hit;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] sel,
                                           input logic [7:0] v);
    logic [31:0] r;
    r = w;
    r[{sel, 3'b000} +: 8] = v;
    return r;
  endfunction

  assign row     = addr_in[5:4];
  assign col     = addr_in[3:2];
  assign bsel    = addr_in[1:0];
  assign col_hit = (col == ADDR_HI);

  assign sum_ab = a_q + b_q;
  assign sum_cd = c_q + d_q;
  assign mix_d  = d_q ^ sum_ab;
  assign mix_b  = b_q ^ sum_cd;

  // Every active state except UN2/FF simply advances to the next encoding.
  assign state_nxt = state_e'(state_q + 4'd1);

  always_comb begin
    case (row)
      2'd0:    rd_word = a_q;
      2'd1:    rd_word = b_q;
      2'd2:    rd_word = c_q;
      default: rd_word = d_q;
    endcase
  end

  assign data_out = col_hit ? rd_word[{bsel, 3'b000} +: 8] : 8'h00;
  assign b_out    = b_q;
  assign c_out    = c_q;
  assign d_out    = d_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  always_comb begin
    a_d = a_q;   b_d = b_q;   c_d = c_q;   d_d = d_q;
    sa_d = sa_q; sb_d = sb_q; sc_d = sc_q; sd_d = sd_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        // Any write blocks start, even one aimed at another column, so all
        // ring lanes make the same start decision.
        if (write) begin
          if (col_hit) begin
            done_d = 1'b0;
            case (row)
              2'd0:    a_d = put_byte(a_q, bsel, data_in);
              2'd1:    b_d = put_byte(b_q, bsel, data_in);
              2'd2:    c_d = put_byte(c_q, bsel, data_in);
              default: d_d = put_byte(d_q, bsel, data_in);
            endcase
          end
        end else if (start) begin
          sa_d = a_q; sb_d = b_q; sc_d = c_q; sd_d = d_q;
          cnt_d   = '0;
          done_d  = 1'b0;
          state_d = COL0;
        end
      end
      COL0, DIAG0: begin
        a_d = sum_ab; d_d = rotl(mix_d, 16); state_d = state_nxt;
      end
      COL1, DIAG1: begin
        c_d = sum_cd; b_d = rotl(mix_b, 12); state_d = state_nxt;
      end
      COL2, DIAG2: begin
        a_d = sum_ab; d_d = rotl(mix_d, 8); state_d = state_nxt;
      end
      COL3, DIAG3: begin
        c_d = sum_cd; b_d = rotl(mix_b, 7); state_d = state_nxt;
      end
      SH0, UN0: begin
        b_d = b_nbr_in; c_d = c_nbr_in; d_d = d_nbr_in; state_d = state_nxt;
      end
      SH1: begin
        c_d = c_nbr_in; d_d = d_nbr_in; state_d = state_nxt;
      end
      SH2: begin
        d_d = d_nbr_in; state_d = state_nxt;
      end
      UN1: begin
        b_d = b_nbr_in; c_d = c_nbr_in; state_d = state_nxt;
      end
      UN2: begin
        b_d = b_nbr_in;
        if (cnt_q < CNT_LAST) begin
          cnt_d   = cnt_q + 4'd1;
          state_d = COL0;
        end else if (FEED_FWD != 0) begin
          state_d = FF;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      FF: begin
        a_d = a_q + sa_q; b_d = b_q + sb_q; c_d = c_q + sc_q; d_d = d_q + sd_q;
        state_d = IDLE;
        done_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      a_q  <= A_INIT; b_q  <= '0; c_q  <= '0; d_q  <= '0;
      sa_q <= '0;     sb_q <= '0; sc_q <= '0; sd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      a_q  <= a_d;  b_q  <= b_d;  c_q  <= c_d;  d_q  <= d_d;
      sa_q <= sa_d; sb_q <= sb_d; sc_q <= sc_d; sd_q <= sd_d;
    end
  end

endmodule
